serializer_nlane_gearbox: RTL and testbench
===========================================

// Module: serializer_nlane_gearbox
// PURPOSE
// - Multi-lane fabric parallel-to-serial gearbox, one clock (serial_clk), valid/ready input.
// - Each lane turns a WIDTH-bit word into BPC bits per clock.
// - BPC=2 drives a DDR output register or buffer; BPC=1 drives an SDR pin.
// - Sits between TMDS/LVDS encoders and the I/O buffers. Used where OSERDES primitives are
//   unavailable or the lane count or width differs from 10.
// - All lanes share one word counter, so lane-to-lane word alignment is guaranteed.
// PARAMETERS
// - LANES      3                 number of serial lanes
// - WIDTH      10                parallel word width per lane
// - BPC        2                 bits per clock per lane: 1 or 2. WIDTH%BPC==0 and WIDTH/BPC>=2.
// - MSB_FIRST  0                 0: bit0 is sent first; 1: bit WIDTH-1 is sent first
// - IDLE_WORD  10'b1101010100    word sent on underflow; the same value on every lane
// PORTS
// - serial_clk     in   1            word-rate x (WIDTH/BPC) clock
// - reset_n        in   1            asynchronous, active-low reset
// - enable         in   1            1: shift/load runs; 0: gearbox frozen
// - in_valid       in   1            in_data holds one word for all lanes
// - in_ready       out  1            handshake completes when in_valid & in_ready
// - in_data        in   LANES*WIDTH  lane k = in_data[k*WIDTH +: WIDTH]
// - ser_out        out  LANES*BPC    lane k = ser_out[k*BPC +: BPC]; [0] is the earlier bit
// - word_start     out  1            high in the cycle the first bits of a word are on ser_out
// - underflow      out  1            sticky: a load slot found no word
// - clr_underflow  in   1            synchronous clear of underflow
// BEHAVIOUR
// - Reset values:
//   - ser_out=0, word_start=0, underflow=0.
//   - Hold register empty, so in_ready=1. Shift registers=0.
//   - cnt=LAST, where LAST=WIDTH/BPC-1. primed=0.
// - load = enable & (cnt==LAST).
// - Enabled edge without load: shift registers move BPC bits toward the output end; cnt+1.
// - Load edge:
//   - cnt<=0.
//   - Shift register takes the hold word if hold is valid, otherwise IDLE_WORD.
//   - MSB_FIRST=1 bit-reverses the word on load.
//   - word_start<=1; word_start is 0 on every other edge.
// - ser_out = shift register low BPC bits, taken directly from registers (no combinational
//   path from inputs).
// - Hold register (1 word):
//   - in_ready = !hold_valid | load. This is combinational; a hold word can be replaced in
//     its own load edge.
//   - At the load edge, handshake and hold valid: shift<=hold, hold<=in_data, hold stays valid.
//   - Handshake outside a load edge: hold<=in_data, hold_valid<=1.
//   - Load with no handshake: hold_valid<=0.
// - Latency: word accepted at edge k reaches ser_out (word_start=1) one cycle after the next
//   load edge. Minimum 1 cycle, maximum LAST+1 cycles.
// - Full-rate streaming with in_valid held high: no idle words, in_ready high once per word
//   period.
// - Underflow:
//   - A load with hold empty sets underflow, but only when primed=1.
//   - primed sets on the first handshake after reset, so idle words before the first word
//     are not errors.
//   - If clr_underflow and a set event fall in the same cycle, set wins.
// - enable=0:
//   - cnt, shift registers and ser_out hold; word_start=0.
//   - The hold register still accepts one word (in_ready=!hold_valid).
//   - Resuming continues mid-word; no bits are lost or repeated.
// - Asserting reset_n low mid-word returns everything to reset values at once.
//   The partly sent word and the hold word are discarded.
// STRUCTURE
// - Package serializer_pkg: LSB_FIRST/MSB_FIRST constants, TMDS control words
//   (10'h354, 10'h0AB, 10'h154, 10'h2AB), function bit_reverse.
// - Sub-module serializer_lane_shift (WIDTH, BPC): per-lane shift register with load/shift
//   enables, instanced LANES times by generate.
// - The top level owns cnt, the hold register control, primed and underflow.
// TESTING
// - Reset: hold reset_n=0 with random inputs.
//   -> ser_out=0, word_start=0, in_ready=1, underflow=0.
// - Single word, LANES=3 WIDTH=10 BPC=2 LSB-first, lane0=10'h353:
//   -> lane0 pairs 2'b11, 00, 01, 01, 11 on consecutive cycles, word_start only on the first.
// - MSB_FIRST=1, lane0=10'h353:
//   -> pairs {b8,b9}=11, {b6,b7}=10, {b4,b5}=10, {b2,b3}=00, {b0,b1}=11, each as {[1],[0]}.
// - Streaming: in_valid held 1 for 100 words with incrementing data.
//   -> no IDLE_WORD, underflow=0, words in order, all lanes aligned.
// - Starvation: after one word, drop in_valid.
//   -> IDLE_WORD 10'h354 on every lane, underflow=1.
//   -> clr_underflow clears it; clr and set in the same cycle -> underflow stays 1.
// - Freeze and reset: enable=0 for 7 cycles mid-word -> output holds, the word resumes intact.
//   Pulse reset_n mid-word -> reset values, the next load sends the next accepted word.

Source files
------------

// File: rtl/serializer_nlane_gearbox_pkg.sv
// Shared constants and helpers for the multi-lane parallel-to-serial gearbox.
package serializer_pkg;

    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    // TMDS control-period words, used as idle fill on DVI/HDMI links
    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    localparam int unsigned REV_MAX = 64;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [REV_MAX-1:0] bit_reverse(input logic [REV_MAX-1:0] v,
                                                       input int unsigned w);
        logic [REV_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REV_MAX; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/serializer_nlane_gearbox_lane_shift.sv
// One lane of the gearbox: loads a word, then shifts BPC bits per enabled clock.
module serializer_lane_shift #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned BPC   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_word,
    output logic [BPC-1:0]   o_bits
);
    import serializer_pkg::*;

    logic [WIDTH-1:0] r_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_word;
        end else if (i_shift) begin
            r_shift <= r_shift >> BPC;
        end
    end

    assign o_bits = r_shift[BPC-1:0];

endmodule

// File: rtl/serializer_nlane_gearbox.sv
// Multi-lane parallel-to-serial gearbox with a one-word hold register and a
// single word counter shared by all lanes, so lanes stay word-aligned.
module serializer_nlane_gearbox #(
    parameter int unsigned      LANES     = 3,
    parameter int unsigned      WIDTH     = 10,
    parameter int unsigned      BPC       = 2,
    parameter bit               MSB_FIRST = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                   serial_clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES*BPC-1:0]   ser_out,
    output logic                   word_start,
    output logic                   underflow,
    input  logic                   clr_underflow
);
    import serializer_pkg::*;

    localparam int unsigned      NBEAT = WIDTH / BPC;
    localparam int unsigned      CNT_W = $clog2(NBEAT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBEAT - 1);

    logic [CNT_W-1:0]       r_cnt;
    logic [LANES*WIDTH-1:0] r_hold;
    logic                   r_hold_valid;
    logic                   r_primed;
    logic                   r_underflow;
    logic                   r_word_start;

    logic w_load;
    logic w_shift;
    logic w_hs;

    assign w_load   = enable & (r_cnt == LAST);
    assign w_shift  = enable & ~w_load;
    // A held word may be replaced in the very edge that moves it to the shifters.
    assign in_ready = ~r_hold_valid | w_load;
    assign w_hs     = in_valid & in_ready;

    always_ff @(posedge serial_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= LAST;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_primed     <= 1'b0;
            r_underflow  <= 1'b0;
            r_word_start <= 1'b0;
        end else begin
            r_word_start <= w_load;
            if (w_load) begin
                r_cnt <= '0;
            end else if (enable) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_hs) begin
                r_hold       <= in_data;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
            if (w_hs) r_primed <= 1'b1;
            // Setting takes priority over a simultaneous clear.
            if (w_load && !r_hold_valid && r_primed) begin
                r_underflow <= 1'b1;
            end else if (clr_underflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign word_start = r_word_start;
    assign underflow  = r_underflow;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0]   w_word;
        logic [REV_MAX-1:0] w_rev;
        logic [WIDTH-1:0]   w_load_word;
        logic               w_unused_rev;

        assign w_word       = r_hold_valid ? r_hold[k*WIDTH +: WIDTH] : IDLE_WORD;
        assign w_rev        = bit_reverse(REV_MAX'(w_word), WIDTH);
        assign w_unused_rev = ^w_rev;
        // The shifter always emits its LSB first, so MSB-first order is a reversed load.
        assign w_load_word  = (MSB_FIRST != LSB_FIRST) ? w_rev[WIDTH-1:0] : w_word;

        serializer_lane_shift #(
            .WIDTH(WIDTH),
            .BPC  (BPC)
        ) u_shift (
            .i_clk  (serial_clk),
            .i_rst_n(reset_n),
            .i_load (w_load),
            .i_shift(w_shift),
            .i_word (w_load_word),
            .o_bits (ser_out[k*BPC +: BPC])
        );
    end

endmodule

// File: tb/tb_serializer_nlane_gearbox.sv
// Directed bench for serializer_nlane_gearbox: an LSB-first and an MSB-first
// instance share all inputs; words are rebuilt from the serial pairs and compared.
module tb_serializer_nlane_gearbox;

    localparam logic [9:0]  IDLE  = 10'h354;
    localparam logic [29:0] IDLE3 = {3{IDLE}};

    logic        serial_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        in_valid;
    logic        clr_underflow;
    logic [29:0] in_data;

    logic        rdy_l, rdy_m, ws_l, ws_m, uf_l, uf_m;
    logic [5:0]  ser_l, ser_m;

    int checks = 0;
    int errors = 0;

    always #5 serial_clk = ~serial_clk;

    serializer_nlane_gearbox #(
        .LANES(3), .WIDTH(10), .BPC(2), .MSB_FIRST(1'b0), .IDLE_WORD(10'h354)
    ) dut_lsb (
        .serial_clk(serial_clk), .reset_n(reset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
        .ser_out(ser_l), .word_start(ws_l), .underflow(uf_l),
        .clr_underflow(clr_underflow)
    );

    serializer_nlane_gearbox #(
        .LANES(3), .WIDTH(10), .BPC(2), .MSB_FIRST(1'b1), .IDLE_WORD(10'h354)
    ) dut_msb (
        .serial_clk(serial_clk), .reset_n(reset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
        .ser_out(ser_m), .word_start(ws_m), .underflow(uf_m),
        .clr_underflow(clr_underflow)
    );

    task automatic tick();
        @(posedge serial_clk);
        #1;
    endtask

    // Rebuild words: LSB instance sends bit 2j+b of each lane in pair j, bit b;
    // MSB instance sends bit 9-(2j+b) there.
    function automatic void assemble(input logic [5:0] lp [5], input logic [5:0] mp [5],
                                     output logic [29:0] wl, output logic [29:0] wm);
        wl = '0;
        wm = '0;
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 3; k++)
                for (int b = 0; b < 2; b++) begin
                    wl[k*10 + 2*j + b]       = lp[j][k*2 + b];
                    wm[k*10 + 9 - (2*j + b)] = mp[j][k*2 + b];
                end
    endfunction

    function automatic logic [29:0] dat(input int i);
        return {10'(10'h200 + i), 10'(10'h100 + i), 10'(i + 1)};
    endfunction

    // Called in the word_start cycle; ends in the cycle showing the last pair.
    task automatic collect(output logic [29:0] wl, output logic [29:0] wm, output int extra);
        logic [5:0] lp [5];
        logic [5:0] mp [5];
        extra = 0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                tick();
                if (ws_l) extra++;
            end
            lp[j] = ser_l;
            mp[j] = ser_m;
        end
        assemble(lp, mp, wl, wm);
    endtask

    task automatic wait_ws(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            tick();
            if (ws_l) ok = 1'b1;
        end
    endtask

    task automatic send(input logic [29:0] d);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        ok = rdy_l;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            ok = rdy_l;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_timeout: in_ready=%b required 1", rdy_l); end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data       = 30'($urandom);
            in_valid      = 1'($urandom_range(0, 1));
            enable        = 1'($urandom_range(0, 1));
            clr_underflow = 1'($urandom_range(0, 1));
            tick();
        end
        checks++; if (ser_l !== 6'd0) begin errors++; $display("FAIL reset_ser_lsb: got %b required 000000", ser_l); end
        checks++; if (ser_m !== 6'd0) begin errors++; $display("FAIL reset_ser_msb: got %b required 000000", ser_m); end
        checks++; if (ws_l !== 1'b0) begin errors++; $display("FAIL reset_word_start: got %b required 0", ws_l); end
        checks++; if (rdy_l !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", rdy_l); end
        checks++; if (uf_l !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b required 0", uf_l); end
        checks++; if (rdy_m !== 1'b1 || uf_m !== 1'b0) begin errors++; $display("FAIL reset_msb_flags: got rdy=%b uf=%b required 1 0", rdy_m, uf_m); end
    endtask

    task automatic test_single_word();
        logic [1:0]  el [5];
        logic [1:0]  em [5];
        logic [5:0]  lp [5];
        logic [5:0]  mp [5];
        logic [29:0] d, wl, wm;
        int          lat;
        bit          ok;
        el = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b11};
        em = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b11};
        d  = {10'h0F0, 10'h2AA, 10'h353};
        enable = 1'b1; in_valid = 1'b0; clr_underflow = 1'b0; in_data = '0;
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        checks++; if (rdy_l !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b required 1", rdy_l); end
        tick();
        in_valid = 1'b0;
        // First edge after reset is a load slot with nothing held: idle word, no underflow.
        checks++; if (ws_l !== 1'b1) begin errors++; $display("FAIL sw_idle_ws: got %b required 1", ws_l); end
        checks++; if (ser_l[1:0] !== 2'b00) begin errors++; $display("FAIL sw_idle_pair: got %b required 00", ser_l[1:0]); end
        checks++; if (uf_l !== 1'b0) begin errors++; $display("FAIL sw_unprimed_uf: got %b required 0", uf_l); end
        lat = 0; ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            tick();
            lat++;
            if (ws_l) ok = 1'b1;
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL sw_latency: got %0d required 5", lat); end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                tick();
                checks++; if (ws_l !== 1'b0) begin errors++; $display("FAIL sw_ws_low[%0d]: got %b required 0", j, ws_l); end
            end
            lp[j] = ser_l;
            mp[j] = ser_m;
            checks++; if (ser_l[1:0] !== el[j]) begin errors++; $display("FAIL sw_pair_lsb[%0d]: got %b required %b", j, ser_l[1:0], el[j]); end
            checks++; if (ser_m[1:0] !== em[j]) begin errors++; $display("FAIL sw_pair_msb[%0d]: got %b required %b", j, ser_m[1:0], em[j]); end
        end
        assemble(lp, mp, wl, wm);
        checks++; if (wl !== d) begin errors++; $display("FAIL sw_word_lsb: got %h required %h", wl, d); end
        checks++; if (wm !== d) begin errors++; $display("FAIL sw_word_msb: got %h required %h", wm, d); end
        checks++; if (uf_l !== 1'b0) begin errors++; $display("FAIL sw_uf_after: got %b required 0", uf_l); end
    endtask

    task automatic test_starvation();
        logic [29:0] wl, wm;
        int          extra;
        tick();
        checks++; if (ws_l !== 1'b1) begin errors++; $display("FAIL st_ws: got %b required 1", ws_l); end
        checks++; if (uf_l !== 1'b1 || uf_m !== 1'b1) begin errors++; $display("FAIL st_underflow: got %b/%b required 1/1", uf_l, uf_m); end
        collect(wl, wm, extra);
        checks++; if (wl !== IDLE3) begin errors++; $display("FAIL st_idle_lsb: got %h required %h", wl, IDLE3); end
        checks++; if (wm !== IDLE3) begin errors++; $display("FAIL st_idle_msb: got %h required %h", wm, IDLE3); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL st_extra_ws: got %0d required 0", extra); end
        clr_underflow = 1'b1;
        tick();
        checks++; if (uf_l !== 1'b1) begin errors++; $display("FAIL st_set_wins: got %b required 1", uf_l); end
        tick();
        checks++; if (uf_l !== 1'b0) begin errors++; $display("FAIL st_cleared: got %b required 0", uf_l); end
        clr_underflow = 1'b0;
    endtask

    task automatic test_streaming();
        fork
            begin : drv
                int n;
                for (int i = 0; i < 100; i++) begin
                    in_data  = dat(i);
                    in_valid = 1'b1;
                    n = 0;
                    while (!rdy_l && n < 40) begin
                        tick();
                        n++;
                    end
                    checks++; if (n >= 40) begin errors++; $display("FAIL stream_drv_timeout[%0d]: in_ready=%b required 1", i, rdy_l); end
                    tick();
                end
                in_valid = 1'b0;
            end
            begin : chk
                logic [29:0] wl, wm;
                int          extra;
                bit          got, found;
                found = 1'b0;
                for (int t = 0; t < 3 && !found; t++) begin
                    wait_ws(got);
                    if (got) begin
                        collect(wl, wm, extra);
                        if (wl !== IDLE3) found = 1'b1;
                    end
                end
                checks++; if (!found) begin errors++; $display("FAIL stream_start: no data word seen, last=%h required %h", wl, dat(0)); end
                if (found) begin
                    for (int j = 0; j < 100; j++) begin
                        if (j > 0) begin
                            tick();
                            checks++; if (ws_l !== 1'b1) begin errors++; $display("FAIL stream_gap[%0d]: word_start=%b required 1", j, ws_l); end
                            collect(wl, wm, extra);
                        end
                        checks++; if (wl !== dat(j)) begin errors++; $display("FAIL stream_lsb[%0d]: got %h required %h", j, wl, dat(j)); end
                        checks++; if (wm !== dat(j)) begin errors++; $display("FAIL stream_msb[%0d]: got %h required %h", j, wm, dat(j)); end
                    end
                end
                checks++; if (uf_l !== 1'b0) begin errors++; $display("FAIL stream_underflow: got %b required 0", uf_l); end
            end
        join
    endtask

    task automatic test_freeze();
        logic [5:0]  lp [5];
        logic [5:0]  mp [5];
        logic [29:0] w1, w2, wl, wm;
        int          extra;
        bit          ok;
        w1 = {10'h0E9, 10'h2B4, 10'h1C7};
        w2 = {10'h3C3, 10'h05A, 10'h12D};
        wait_ws(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fz_sync: word_start=%b required 1", ws_l); end
        send(w1);
        wait_ws(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fz_ws: word_start=%b required 1", ws_l); end
        lp[0] = ser_l; mp[0] = ser_m;
        tick();
        lp[1] = ser_l; mp[1] = ser_m;
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = w2;
        checks++; if (rdy_l !== 1'b1) begin errors++; $display("FAIL fz_ready: got %b required 1", rdy_l); end
        for (int f = 0; f < 7; f++) begin
            tick();
            in_valid = 1'b0;
            checks++; if (ser_l !== lp[1] || ser_m !== mp[1]) begin errors++; $display("FAIL fz_hold[%0d]: got %b/%b required %b/%b", f, ser_l, ser_m, lp[1], mp[1]); end
            checks++; if (ws_l !== 1'b0) begin errors++; $display("FAIL fz_ws_low[%0d]: got %b required 0", f, ws_l); end
        end
        checks++; if (rdy_l !== 1'b0) begin errors++; $display("FAIL fz_hold_full: in_ready=%b required 0", rdy_l); end
        enable = 1'b1;
        for (int j = 2; j < 5; j++) begin
            tick();
            lp[j] = ser_l; mp[j] = ser_m;
        end
        assemble(lp, mp, wl, wm);
        checks++; if (wl !== w1) begin errors++; $display("FAIL fz_word_lsb: got %h required %h", wl, w1); end
        checks++; if (wm !== w1) begin errors++; $display("FAIL fz_word_msb: got %h required %h", wm, w1); end
        tick();
        checks++; if (ws_l !== 1'b1) begin errors++; $display("FAIL fz_next_ws: got %b required 1", ws_l); end
        collect(wl, wm, extra);
        checks++; if (wl !== w2 || wm !== w2) begin errors++; $display("FAIL fz_held_word: got %h/%h required %h", wl, wm, w2); end
    endtask

    task automatic test_reset_mid();
        logic [29:0] wl, wm, w5;
        int          extra;
        bit          ok;
        w5 = {10'h111, 10'h222, 10'h0CC};
        wait_ws(ok);
        send({10'h3FF, 10'h3FF, 10'h3FF});
        wait_ws(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_ws: word_start=%b required 1", ws_l); end
        tick();
        send({10'h155, 10'h155, 10'h155});
        reset_n = 1'b0;
        #1;
        checks++; if (ser_l !== 6'd0 || ser_m !== 6'd0) begin errors++; $display("FAIL rm_ser: got %b/%b required 0/0", ser_l, ser_m); end
        checks++; if (ws_l !== 1'b0) begin errors++; $display("FAIL rm_ws_low: got %b required 0", ws_l); end
        checks++; if (rdy_l !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b required 1", rdy_l); end
        checks++; if (uf_l !== 1'b0) begin errors++; $display("FAIL rm_underflow: got %b required 0", uf_l); end
        tick();
        reset_n = 1'b1;
        send(w5);
        checks++; if (ws_l !== 1'b1) begin errors++; $display("FAIL rm_first_load: got %b required 1", ws_l); end
        wait_ws(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_w5_ws: word_start=%b required 1", ws_l); end
        collect(wl, wm, extra);
        checks++; if (wl !== w5) begin errors++; $display("FAIL rm_word_lsb: got %h required %h", wl, w5); end
        checks++; if (wm !== w5) begin errors++; $display("FAIL rm_word_msb: got %h required %h", wm, w5); end
        checks++; if (uf_l !== 1'b0) begin errors++; $display("FAIL rm_uf_after: got %b required 0", uf_l); end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; clr_underflow = 1'b0; in_data = '0;
        test_reset();
        test_single_word();
        test_starvation();
        test_streaming();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
